fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the program counter and drives the instruction-memory address.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter and drives the instruction-memory address.
// Registers the fetched word together with its PC and offers it to decode.
// Taken branches and jumps flush the stage through a one-cycle redirect.
// A misaligned or out-of-range PC halts fetch in a sticky FAULT state.
//
// Handshake: the output word transfers on any rising edge where
// instr_valid_o & instr_ready_i. While instr_valid_o is high and instr_ready_i
// is low, instr_o and instr_pc_o do not change. instr_valid_o never falls
// without a transfer, except for a redirect flush, a fault or a reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o,
  output logic [0:0]  state_o
);

  localparam logic [0:0]  RUN      = 1'b0;
  localparam logic [0:0]  FAULT    = 1'b1;
  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic pc_ok;
  logic redirect_ok;
  logic out_free;
  logic handshake;

  // PC legality, output-slot availability and transfer detection.
  always_comb begin
    pc_ok       = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
    redirect_ok = (redirect_pc_i[1:0] == 2'b00) && (redirect_pc_i < PC_LIMIT);
    out_free    = !valid_q || instr_ready_i;
    handshake   = valid_q && instr_ready_i;
  end

  // Next-state logic: redirect beats fetch; a bad PC moves to FAULT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    // A completed transfer is counted whatever else happens this cycle.
    if (handshake) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          // Flush whatever is held; no fetch this cycle.
          valid_d = 1'b0;
          if (redirect_ok) begin
            pc_d = redirect_pc_i;
          end else begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc_i;
          end
        end else if (out_free) begin
          if (pc_ok) begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else begin
            // Any held word is being consumed this cycle, so it is safe to drop.
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            valid_d    = 1'b0;
          end
        end
        // Otherwise backpressure: everything holds.
      end
      FAULT: begin
        // Terminal until reset; only drains a held word.
        if (handshake) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = FAULT;
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Output wiring; the memory address is the live PC.
  always_comb begin
    imem_addr_o   = pc_q;
    instr_valid_o = valid_q;
    instr_o       = instr_q;
    instr_pc_o    = instr_pc_q;
    fault_o       = fault_q;
    fault_pc_o    = fault_pc_q;
    fetch_count_o = count_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory word k holds 4k, expected PCs are queued per
// scenario and retired by a monitor on every transfer.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  logic [0:0]  state;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .fault_o          (fault),
    .fault_pc_o       (fault_pc),
    .fetch_count_o    (fetch_count),
    .state_o          (state)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'(k * 4);
  end

  assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  // Scoreboard: a transfer happens on the next rising edge whenever valid &
  // ready are seen here, so the expected PC is retired now.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got instr_pc=%h with empty expected queue", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr_pc !== e || instr !== e) begin
          failures++;
          $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h", instr_pc, instr, e, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'd0 ||
        instr !== 32'd0 || instr_pc !== 32'd0 || fault_pc !== 32'd0 || state !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b fault=%b cnt=%h addr=%h instr=%h ipc=%h fpc=%h st=%b, expected all zero",
               instr_valid, fault, fetch_count, imem_addr, instr, instr_pc, fault_pc, state);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(pcs[i]);
    instr_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== pcs[i] || instr !== pcs[i]) begin
        failures++;
        $display("FAIL seq_word%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", i, instr_valid, instr_pc, instr, pcs[i], pcs[i]);
      end
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL seq_count: got %0d expected 4", fetch_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL seq_drain: %0d expected words not delivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h8 || instr_pc !== 32'h8 || imem_addr !== 32'hC || fetch_count !== 32'd2) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b instr=%h pc=%h addr=%h cnt=%0d, expected 1 8 8 c 2",
                 i, instr_valid, instr, instr_pc, imem_addr, fetch_count);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hC || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL bp_resume: valid=%b pc=%h cnt=%0d, expected 1 c 3", instr_valid, instr_pc, fetch_count);
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL bp_drain: left=%0d cnt=%0d, expected 0 4", exp_q.size(), fetch_count);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    exp_q.push_back(32'h0);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick(); tick();
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h20) begin
      failures++;
      $display("FAIL redir_flush: valid=%b addr=%h, expected 0 20", instr_valid, imem_addr);
    end
    exp_q.push_back(32'h20);
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h20) begin
      failures++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, expected 1 20 20", instr_valid, instr_pc, instr);
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (fetch_count !== 32'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL redir_count: cnt=%0d left=%0d, expected 2 0", fetch_count, exp_q.size());
    end
  endtask

  task automatic test_fault_redirect();
    do_reset();
    exp_q.push_back(32'h0);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    tick();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 32'h22 || instr_valid !== 1'b0 || fetch_count !== 32'd1 || state !== 1'b1) begin
      failures++;
      $display("FAIL fault_entry: fault=%b fpc=%h valid=%b cnt=%0d st=%b, expected 1 22 0 1 1",
               fault, fault_pc, instr_valid, fetch_count, state);
    end
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 32'h22 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_sticky: fault=%b fpc=%h addr=%h valid=%b, expected 1 22 4 0", fault, fault_pc, imem_addr, instr_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'h0 || state !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: fault=%b addr=%h st=%b, expected 0 0 0", fault, imem_addr, state);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    exp_q.push_back(32'h3F8); exp_q.push_back(32'h3FC);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F8;
    rst = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 32'h400 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_fault: fault=%b fpc=%h valid=%b, expected 1 400 0", fault, fault_pc, instr_valid);
    end
    tick(); tick();
    instr_ready = 1'b0;
    checks++;
    if (fetch_count !== 32'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL overrun_count: cnt=%0d left=%0d, expected 2 0", fetch_count, exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    int pushed;
    pushed = 48;
    do_reset();
    for (int i = 0; i < pushed; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    instr_ready = 1'b0;
    checks++;
    if (fetch_count !== 32'(pushed - exp_q.size())) begin
      failures++;
      $display("FAIL rand_count: cnt=%0d expected %0d", fetch_count, pushed - exp_q.size());
    end
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0 || instr_pc !== exp_q[0]) begin
      failures++;
      $display("FAIL rand_head: valid=%b pc=%h, expected 1 and next queued pc", instr_valid, instr_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: valid=%b fault=%b cnt=%0d addr=%h, expected 0 0 0 0",
               instr_valid, fault, fetch_count, imem_addr);
    end
    tick();
    checks++;
    if (fetch_count !== 32'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL async_no_count: cnt=%0d left=%0d, expected 0 0", fetch_count, exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_overrun();
    test_random_ready();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
